session_fsm: RTL and testbench
==============================

// Module: session_fsm
// PURPOSE
//  Parametrised session controller: detects a session start on a DW-bit data
//  stream, tracks it through ON/OFF/WAIT phases, and returns to IDLE. Adds an
//  ON-phase timeout with an error state, a programmable WAIT length,
//  completion/timeout pulses and saturating session/error counters.
//  Sits between the stream input stage and the status/CSR logic.
// PARAMETERS
//  DW        8      data width
//  IDLE_PAT  8'h0F  value that does not start a session (DW bits)
//  STOP_PAT  8'hF0  value that ends the ON phase (DW bits)
//  TIMEOUT   16     max cycles spent in ON; legal range >=2
//  WAIT_CYC  1      cycles spent in WAIT; legal range >=1
//  CNT_W     8      width of sess_cnt / err_cnt
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      reset, synchronous, active-low
//  data      in   DW     stream data, sampled every cycle
//  en        in   1      qualifier for start / OFF exit
//  clr       in   1      synchronous soft clear
//  state     out  3      current state code
//  busy      out  1      state != IDLE (combinational from state)
//  done      out  1      1-cycle pulse: session completed
//  timeout   out  1      1-cycle pulse: ON phase timed out
//  sess_cnt  out  CNT_W  completed sessions, saturating
//  err_cnt   out  CNT_W  timeouts, saturating
// BEHAVIOUR
//  - One clock domain; one clock and one synchronous active-low reset (clk,
//    rst_n). Priority: rst_n low > clr high > normal operation.
//  - Reset/clr: state=IDLE, timers=0, done=0, timeout=0, sess_cnt=0,
//    err_cnt=0. Both take effect at the next rising edge.
//  - Encoding: IDLE 3'b000, ON 001, OFF 010, WAIT 100, ERR 111. Any other code
//    goes to IDLE on the next cycle and produces no pulse and no count change.
//  - Next state is combinational from state, data, en, timers, and is fully
//    sensitive (always @*). State, timers and pulses are registered.
//  - IDLE: en && data!=IDLE_PAT -> ON, clear ON timer; else stay.
//  - ON: data==STOP_PAT -> OFF (checked first); else if on_tmr==TIMEOUT-1 -> ERR;
//    else stay and increment on_tmr. ON therefore lasts at most TIMEOUT cycles.
//    A stop on the last allowed cycle wins over the timeout.
//  - OFF: en -> WAIT, load wait_tmr=WAIT_CYC-1; else stay (no timeout).
//  - WAIT: wait_tmr==0 -> IDLE; else decrement. WAIT lasts exactly WAIT_CYC
//    cycles. data and en are ignored.
//  - ERR: en==0 -> IDLE; else stay. A held en cannot restart a session.
//  - done <= (state==WAIT && wait_tmr==0), so done is high in the first IDLE
//    cycle. timeout <= (ON->ERR transition), so it is high in the first ERR cycle.
//  - sess_cnt increments on the same edge that sets done. err_cnt increments
//    on the same edge that sets timeout. Both stick at 2^CNT_W-1.
//  - clr in any state aborts the session: no done/timeout pulse for it.
//  - Timers are sized $clog2(TIMEOUT) and $clog2(WAIT_CYC)+1, with no wrap in
//    legal operation.
// TESTING  (DW=8, TIMEOUT=6, WAIT_CYC=3, CNT_W=2 unless stated)
//  1 rst_n=0 for 2 cycles mid-ON, then 1 -> state=000, all outputs 0 on the
//    first edge with rst_n=0.
//  2 en=1,data=12 -> ON; data=F0 -> OFF; en=1 -> WAIT for 3 cycles -> IDLE
//    with done=1 for 1 cycle and sess_cnt=1.
//  3 In IDLE: en=1,data=0F and en=0,data=12 for 10 cycles -> state stays 000,
//    busy=0.
//  4 Enter ON with data held at 00 -> ERR after 6 ON cycles, timeout=1 for 1
//    cycle, err_cnt=1; ERR held while en=1; en=0 -> IDLE.
//  5 Enter ON, data=F0 on the 6th ON cycle -> OFF, timeout stays 0, err_cnt
//    unchanged.
//  6 Run 5 complete sessions -> sess_cnt=3 (saturated); clr=1 during WAIT ->
//    IDLE, counters=0, no done pulse.

Source files
------------

// File: rtl/session_fsm.sv
// Session controller: IDLE -> ON -> OFF -> WAIT -> IDLE, with ON timeout into ERR and saturating counters.
// Latency: state/pulses/counters registered, update one edge after inputs; no backpressure, data sampled every cycle.
module session_fsm #(
    parameter int             DW       = 8,
    parameter logic [DW-1:0]  IDLE_PAT = 8'h0F,
    parameter logic [DW-1:0]  STOP_PAT = 8'hF0,
    parameter int             TIMEOUT  = 16,
    parameter int             WAIT_CYC = 1,
    parameter int             CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    data,
    input  logic             en,
    input  logic             clr,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] sess_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int ON_TW   = $clog2(TIMEOUT);
    localparam int WAIT_TW = $clog2(WAIT_CYC) + 1;
    localparam logic [ON_TW-1:0]   ON_LAST   = ON_TW'(TIMEOUT - 1);
    localparam logic [WAIT_TW-1:0] WAIT_LAST = WAIT_TW'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_ON   = 3'b001,
        S_OFF  = 3'b010,
        S_WAIT = 3'b100,
        S_ERR  = 3'b111
    } state_t;

    state_t             r_state;
    logic [ON_TW-1:0]   r_on_tmr;
    logic [WAIT_TW-1:0] r_wait_tmr;
    logic               r_done;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_sess_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    state_t             w_state_nxt;
    logic [ON_TW-1:0]   w_on_tmr_nxt;
    logic [WAIT_TW-1:0] w_wait_tmr_nxt;
    logic               w_done_nxt;
    logic               w_timeout_nxt;

    always_comb begin
        w_state_nxt    = r_state;
        w_on_tmr_nxt   = r_on_tmr;
        w_wait_tmr_nxt = r_wait_tmr;
        w_done_nxt     = 1'b0;
        w_timeout_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en && data != IDLE_PAT) begin
                    w_state_nxt  = S_ON;
                    w_on_tmr_nxt = '0;
                end
            end
            S_ON: begin
                // Stop is checked before the timer so a stop on the last cycle wins.
                if (data == STOP_PAT) begin
                    w_state_nxt = S_OFF;
                end else if (r_on_tmr == ON_LAST) begin
                    w_state_nxt   = S_ERR;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_on_tmr_nxt = r_on_tmr + ON_TW'(1);
                end
            end
            S_OFF: begin
                if (en) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_tmr_nxt = WAIT_LAST;
                end
            end
            S_WAIT: begin
                if (r_wait_tmr == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_wait_tmr_nxt = r_wait_tmr - WAIT_TW'(1);
                end
            end
            S_ERR: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // clr has the same effect as reset, so both share one branch.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state    <= S_IDLE;
            r_on_tmr   <= '0;
            r_wait_tmr <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_sess_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_on_tmr   <= w_on_tmr_nxt;
            r_wait_tmr <= w_wait_tmr_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
            if (w_done_nxt && r_sess_cnt != CNT_MAX) begin
                r_sess_cnt <= r_sess_cnt + CNT_W'(1);
            end
            if (w_timeout_nxt && r_err_cnt != CNT_MAX) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign state    = r_state;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign timeout  = r_timeout;
    assign sess_cnt = r_sess_cnt;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_session_fsm.sv
// Bench for session_fsm: each cycle's expected outputs are queued when inputs are driven
// and popped for comparison one edge later.
module tb_session_fsm;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_ON   = 3'b001;
    localparam logic [2:0] S_OFF  = 3'b010;
    localparam logic [2:0] S_WAIT = 3'b100;
    localparam logic [2:0] S_ERR  = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       en;
    logic       clr;
    logic [2:0] state;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [1:0] sess_cnt;
    logic [1:0] err_cnt;

    typedef struct packed {
        logic [2:0] st;
        logic       dn;
        logic       to;
        logic [1:0] sc;
        logic [1:0] ec;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         step    = 0;
    logic [1:0] esc     = 2'd0;
    logic [1:0] eec     = 2'd0;

    session_fsm #(
        .DW(8), .IDLE_PAT(8'h0F), .STOP_PAT(8'hF0),
        .TIMEOUT(6), .WAIT_CYC(3), .CNT_W(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .data(data), .en(en), .clr(clr),
        .state(state), .busy(busy), .done(done), .timeout(timeout),
        .sess_cnt(sess_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", tag, step, obs, exp_v);
        end
    endtask

    task automatic cyc(input logic [7:0] d, input logic e, input logic c, input logic r,
                       input logic [2:0] st, input logic dn, input logic to);
        exp_t x;
        data  = d;
        en    = e;
        clr   = c;
        rst_n = r;
        sb_q.push_back('{st: st, dn: dn, to: to, sc: esc, ec: eec});
        @(posedge clk);
        #1;
        step++;
        x = sb_q.pop_front();
        check("state",    {5'd0, state},    {5'd0, x.st});
        check("busy",     {7'd0, busy},     {7'd0, (x.st != S_IDLE)});
        check("done",     {7'd0, done},     {7'd0, x.dn});
        check("timeout",  {7'd0, timeout},  {7'd0, x.to});
        check("sess_cnt", {6'd0, sess_cnt}, {6'd0, x.sc});
        check("err_cnt",  {6'd0, err_cnt},  {6'd0, x.ec});
    endtask

    // Full session from IDLE; OFF is held one extra cycle without en.
    task automatic full_session();
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_ON,   1'b0, 1'b0);
        cyc(8'hF0, 1'b0, 1'b0, 1'b1, S_OFF,  1'b0, 1'b0);
        cyc(8'hF0, 1'b0, 1'b0, 1'b1, S_OFF,  1'b0, 1'b0);
        cyc(8'h55, 1'b1, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        esc = (esc == 2'd3) ? 2'd3 : esc + 2'd1;
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_IDLE, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);
    endtask

    initial begin
        data  = 8'h00;
        en    = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;

        // Reset from power-up.
        repeat (2) cyc(8'h00, 1'b0, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0);

        // IDLE must ignore the idle pattern and an unqualified start.
        repeat (5) cyc(8'h0F, 1'b1, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);
        repeat (5) cyc(8'h12, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);

        // One complete session.
        full_session();

        // ON timeout after 6 ON cycles, ERR held while en=1.
        cyc(8'h00, 1'b1, 1'b0, 1'b1, S_ON, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(8'h00, 1'b1, 1'b0, 1'b1, S_ON, 1'b0, 1'b0);
        eec = eec + 2'd1;
        cyc(8'h00, 1'b1, 1'b0, 1'b1, S_ERR, 1'b0, 1'b1);
        repeat (3) cyc(8'h12, 1'b1, 1'b0, 1'b1, S_ERR, 1'b0, 1'b0);
        cyc(8'h12, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);
        cyc(8'h12, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);

        // Reset asserted mid-ON clears state and both counters.
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_ON, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0, 1'b1, S_ON, 1'b0, 1'b0);
        esc = 2'd0;
        eec = 2'd0;
        repeat (2) cyc(8'h00, 1'b1, 1'b0, 1'b0, S_IDLE, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);

        // Stop on the last allowed ON cycle beats the timeout.
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_ON, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(8'h00, 1'b0, 1'b0, 1'b1, S_ON, 1'b0, 1'b0);
        cyc(8'hF0, 1'b0, 1'b0, 1'b1, S_OFF,  1'b0, 1'b0);
        cyc(8'hF0, 1'b1, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        esc = esc + 2'd1;
        cyc(8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b1, 1'b0);

        // Five more sessions drive sess_cnt into saturation.
        for (int i = 0; i < 5; i++) full_session();

        // clr during WAIT aborts the session with no done pulse.
        cyc(8'h12, 1'b1, 1'b0, 1'b1, S_ON,   1'b0, 1'b0);
        cyc(8'hF0, 1'b0, 1'b0, 1'b1, S_OFF,  1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0, 1'b1, S_WAIT, 1'b0, 1'b0);
        esc = 2'd0;
        eec = 2'd0;
        cyc(8'h00, 1'b0, 1'b1, 1'b1, S_IDLE, 1'b0, 1'b0);
        repeat (4) cyc(8'h00, 1'b0, 1'b0, 1'b1, S_IDLE, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at step %0d", step);
        $fatal(1, "watchdog");
    end

endmodule
